// File: rtl/display_pkg.sv
// Shared types and segment constants for the BCD score display.
// Segments are active-low, bit order a..g = bits 0..6.
package display_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_CODES [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0011000   // 9
    };

endpackage

// File: rtl/seg7_digit.sv
// One BCD digit to active-low 7-segment pattern; blank (or a non-decimal
// code) drives all segments off.
module seg7_digit
    import display_pkg::*;
(
    input  bcd_t digit,
    input  logic blank,
    output seg_t seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && digit <= 4'd9) seg = SEG_CODES[digit];
    end

endmodule

// File: rtl/bcd_score_display.sv
// N-digit saturating BCD score counter with registered 7-segment output,
// leading-zero blanking and tick-driven blink.
module bcd_score_display
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 2000000,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  add_valid,
    input  logic [3:0]            add_value,
    input  logic                  blink_en,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [7*DIGITS-1:0]   display,
    output logic                  overflow,
    output logic                  tick
);

    localparam int CW = $clog2(TICK_DIV);

    function automatic logic [7*DIGITS-1:0] reset_display();
        logic [7*DIGITS-1:0] r;
        for (int k = 0; k < DIGITS; k++)
            r[7*k +: 7] = (LZ_BLANK != 0 && k > 0) ? SEG_BLANK : SEG_CODES[0];
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] RST_DISPLAY = reset_display();

    // ---------------- tick counter ----------------
    logic [CW-1:0] cnt;
    logic          wrap;
    logic          phase;

    assign wrap = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            tick  <= 1'b0;
            phase <= 1'b0;
        end else begin
            cnt   <= wrap ? '0 : cnt + 1'b1;
            tick  <= wrap;
            // Phase flips on the same edge that raises tick.
            phase <= blink_en ? (phase ^ wrap) : 1'b0;
        end
    end

    // ---------------- decimal ripple add ----------------
    logic [4*DIGITS-1:0] sum_bcd;
    logic [4:0]          carry;
    logic [4:0]          dsum;

    always_comb begin
        sum_bcd = '0;
        dsum    = '0;
        carry   = (add_value > 4'd9) ? 5'd9 : {1'b0, add_value};
        for (int k = 0; k < DIGITS; k++) begin
            dsum = {1'b0, score_bcd[4*k +: 4]} + carry;
            if (dsum > 5'd9) begin
                sum_bcd[4*k +: 4] = 4'(dsum - 5'd10);
                carry             = 5'd1;
            end else begin
                sum_bcd[4*k +: 4] = dsum[3:0];
                carry             = 5'd0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            score_bcd <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            score_bcd <= '0;
            overflow  <= 1'b0;
        end else if (add_valid) begin
            if (carry[0]) begin
                score_bcd <= {DIGITS{4'h9}};
                overflow  <= 1'b1;
            end else begin
                score_bcd <= sum_bcd;
            end
        end
    end

    // ---------------- display ----------------
    logic [DIGITS-1:0]   blank;
    logic                hi_zero;
    logic [7*DIGITS-1:0] seg_next;

    // hi_zero tracks "this digit and all above are zero", scanning from the top.
    always_comb begin
        hi_zero = 1'b1;
        blank   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hi_zero  = hi_zero & (score_bcd[4*k +: 4] == 4'd0);
            blank[k] = phase | ((LZ_BLANK != 0) && (k != 0) && hi_zero);
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        seg7_digit u_digit (
            .digit (score_bcd[4*k +: 4]),
            .blank (blank[k]),
            .seg   (seg_next[7*k +: 7])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) display <= RST_DISPLAY;
        else       display <= seg_next;
    end

endmodule

// File: tb/tb_bcd_score_display.sv
// Randomized + directed bench for bcd_score_display against an integer-level
// reference model of score, tick, blink phase and display.
module tb_bcd_score_display;

    localparam int DIGITS = 4;
    localparam int TDIV   = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        add_valid = 1'b0;
    logic [3:0]  add_value = 4'd0;
    logic        blink_en = 1'b0;
    logic [15:0] score_bcd;
    logic [27:0] display;
    logic        overflow;
    logic        tick;

    bcd_score_display #(.DIGITS(DIGITS), .TICK_DIV(TDIV), .LZ_BLANK(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .add_valid (add_valid),
        .add_value (add_value),
        .blink_en  (blink_en),
        .score_bcd (score_bcd),
        .display   (display),
        .overflow  (overflow),
        .tick      (tick)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [0:9];
    int          m_score, m_cnt;
    logic        m_ovf, m_tick, m_phase;
    logic [27:0] m_disp;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] model_disp(input int v, input logic ph);
        logic [27:0] r;
        int p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            if (ph || (k > 0 && v < p)) r[7*k +: 7] = 7'h7F;
            else                         r[7*k +: 7] = seg_tab[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_score = 0; m_cnt = 0; m_ovf = 0; m_tick = 0; m_phase = 0;
        m_disp  = model_disp(0, 1'b0);
    endtask

    task automatic model_edge();
        logic [27:0] nd;
        logic        w;
        int          amt;
        nd      = model_disp(m_score, m_phase);
        w       = (m_cnt == TDIV - 1);
        m_tick  = w;
        m_cnt   = w ? 0 : m_cnt + 1;
        m_phase = blink_en ? (m_phase ^ w) : 1'b0;
        if (clear) begin
            m_score = 0; m_ovf = 0;
        end else if (add_valid) begin
            amt = (add_value > 9) ? 9 : int'(add_value);
            if (m_score + amt > 9999) begin
                m_score = 9999; m_ovf = 1;
            end else begin
                m_score = m_score + amt;
            end
        end
        m_disp = nd;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".score"}, 64'(score_bcd), 64'(to_bcd(m_score)));
        chk({tag, ".ovf"},   64'(overflow),  64'(m_ovf));
        chk({tag, ".tick"},  64'(tick),      64'(m_tick));
        chk({tag, ".disp"},  64'(display),   64'(m_disp));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic add(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            add_valid = 1'b1; add_value = 4'(v);
            step("add");
        end
        add_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; step("clear"); clear = 1'b0;
    endtask

    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h18;
        model_reset();

        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst.disp",  64'(display),   64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        chk("rst.score", 64'(score_bcd), 64'h0);
        chk("rst.tick",  64'(tick),      64'h0);
        @(negedge clock);
        reset = 1'b0;

        // ticks at cycles 5, 10, 15
        for (int c = 1; c <= 16; c++) begin
            step("idle");
            chk("tick_cycle", 64'(tick), 64'((c % TDIV) == 0));
        end

        // decimal carry 0999 -> 1000
        add(9, 111);
        chk("load999", 64'(score_bcd), 64'h0999);
        add(1, 1);
        chk("carry", 64'(score_bcd), 64'h1000);
        step("carry_disp");
        chk("carry_disp", 64'(display), 64'({7'h79, 7'h40, 7'h40, 7'h40}));

        // saturation
        do_clear();
        add(9, 1110);
        add(5, 1);
        chk("load9995", 64'(score_bcd), 64'h9995);
        add(7, 1);
        chk("sat", 64'(score_bcd), 64'h9999);
        chk("sat_ovf", 64'(overflow), 64'h1);
        add(3, 1);
        chk("sat2", 64'(score_bcd), 64'h9999);
        chk("sat2_ovf", 64'(overflow), 64'h1);
        do_clear();
        chk("clr_ovf", 64'(overflow), 64'h0);

        // clamp, zero-add and clear priority
        add(12, 1);
        chk("clamp", 64'(score_bcd), 64'h0009);
        add(0, 1);
        chk("add0", 64'(score_bcd), 64'h0009);
        clear = 1'b1; add_valid = 1'b1; add_value = 4'd5;
        step("clr_pri");
        clear = 1'b0; add_valid = 1'b0;
        chk("clr_pri", 64'(score_bcd), 64'h0);

        // blink at 0042
        add(9, 4); add(6, 1);
        blink_en = 1'b1;
        repeat (30) step("blink");
        blink_en = 1'b0;
        repeat (4) step("unblink");

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            add_valid = ($urandom % 3) != 0;
            add_value = 4'($urandom % 16);
            clear     = ($urandom % 200) == 0;
            if (($urandom % 40) == 0) blink_en = ~blink_en;
            step("rand");
        end
        clear = 1'b0; add_valid = 1'b0;

        // async reset during a blanked blink phase at 1234
        do_clear();
        add(9, 137); add(1, 1);
        chk("load1234", 64'(score_bcd), 64'h1234);
        blink_en = 1'b1;
        begin
            int budget = 40;
            while (!(m_phase && m_disp == 28'hFFFFFFF) && budget > 0) begin
                step("wait_blank");
                budget--;
            end
            chk("blank_reached", 64'(budget > 0), 64'h1);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("arst.score", 64'(score_bcd), 64'h0);
        chk("arst.ovf",   64'(overflow),  64'h0);
        chk("arst.tick",  64'(tick),      64'h0);
        chk("arst.disp",  64'(display),   64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        @(posedge clock);
        #1;
        check_all("arst_hold");
        @(negedge clock);
        reset = 1'b0;
        blink_en = 1'b0;
        for (int c = 1; c <= 12; c++) step("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
